// File: rtl/instruction_aligner.sv
// Instruction aligner: turns a stream of 32-bit fetch words into a stream of
// 16-bit (compressed) and 32-bit instructions. A halfword buffer carries the
// upper half of a word across fetches so 32-bit instructions may straddle
// a word boundary. A single output register presents one instruction at a time.
module instruction_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_compressed
);

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'd1;

  logic [31:0] pc;
  logic [15:0] hbuf;
  logic        hvalid;
  logic        skip_low;

  logic        advance;
  logic        hbuf_is_c;
  logic        low_is_c;
  logic        rule_a;
  logic        rule_b;
  logic        rule_c;
  logic        rule_d;
  logic        rule_e;
  logic        emit;
  logic        emit_c;
  logic [31:0] emit_data;
  logic        load_hbuf;
  logic [31:0] exp_word_addr;

  // Candidate selection: which alignment rule fires this cycle (flush wins).
  always_comb begin
    advance   = !inst_valid || inst_ready;
    hbuf_is_c = (hbuf[1:0] != 2'b11);
    low_is_c  = (fetch_data[1:0] != 2'b11);

    rule_a = !flush && hvalid && hbuf_is_c && advance;
    rule_b = !flush && hvalid && !hbuf_is_c && fetch_valid && advance;
    // Skipping the low half of a redirect target word emits nothing, so it
    // does not need the output register and proceeds even under backpressure.
    rule_c = !flush && !hvalid && skip_low && fetch_valid;
    rule_d = !flush && !hvalid && !skip_low && fetch_valid && low_is_c && advance;
    rule_e = !flush && !hvalid && !skip_low && fetch_valid && !low_is_c && advance;

    emit      = rule_a || rule_b || rule_d || rule_e;
    emit_c    = rule_a || rule_d;
    load_hbuf = rule_b || rule_c || rule_d;

    emit_data = fetch_data;
    if (rule_a) begin
      emit_data = {16'h0000, hbuf};
    end else if (rule_b) begin
      emit_data = {fetch_data[15:0], hbuf};
    end else if (rule_d) begin
      emit_data = {16'h0000, fetch_data[15:0]};
    end

    fetch_ready = !reset && (rule_b || rule_c || rule_d || rule_e);
  end

  // With a buffered upper half, the next word needed starts right after it.
  assign exp_word_addr = hvalid ? ((pc + 32'd2) & ~32'd3) : (pc & ~32'd3);

  // Alignment state: program counter, halfword buffer and redirect skip flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= PC_INIT;
      hbuf     <= 16'h0000;
      hvalid   <= 1'b0;
      skip_low <= RESET_PC[1];
    end else if (flush) begin
      pc       <= redirect_pc & ~32'd1;
      hvalid   <= 1'b0;
      skip_low <= redirect_pc[1];
    end else begin
      if (emit) begin
        pc <= pc + (emit_c ? 32'd2 : 32'd4);
      end
      if (load_hbuf) begin
        hbuf   <= fetch_data[31:16];
        hvalid <= 1'b1;
      end else if (rule_a) begin
        hvalid <= 1'b0;
      end
      if (rule_c) begin
        skip_low <= 1'b0;
      end
    end
  end

  // Output register: loads on emit, drains when accepted, holds under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_valid      <= 1'b0;
      inst_data       <= 32'h0000_0000;
      inst_pc         <= 32'h0000_0000;
      inst_compressed <= 1'b0;
    end else if (flush) begin
      inst_valid <= 1'b0;
    end else if (emit) begin
      inst_valid      <= 1'b1;
      inst_data       <= emit_data;
      inst_pc         <= pc;
      inst_compressed <= emit_c;
    end else if (advance) begin
      inst_valid <= 1'b0;
    end
  end

  // Upstream must deliver the word that continues the current alignment.
  a_fetch_pc: assert property (@(posedge clk) disable iff (reset)
    fetch_ready |-> (fetch_pc == exp_word_addr));

endmodule
